// File: rtl/token_link_pkg.sv
// Shared constants and state encoding for the token-router serial transmit path.
//   PKT_W     : packet width carried on the serial link
//   PREAMBLE  : frame start pattern, sent from bit 5 down to bit 0
//   GAP_MIN   : smallest idle-high gap the downstream receiver tolerates
//   CNT_W     : width of the frame sequencing counter
//   ID_W      : width of the encoded requester index
//   IDLE/PRE/DATA/GAP : one-hot transmitter state codes
package token_link_pkg;

    localparam int unsigned PKT_W   = 55;
    localparam int unsigned PRE_LEN = 6;
    localparam int unsigned GAP_MIN = 2;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned ID_W    = 3;

    localparam logic [PRE_LEN-1:0] PREAMBLE = 6'b011111;

    localparam logic [3:0] IDLE = 4'b0001;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] DATA = 4'b0100;
    localparam logic [3:0] GAP  = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE = IDLE,
        ST_PRE  = PRE,
        ST_DATA = DATA,
        ST_GAP  = GAP
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req starting at ptr, wrapping modulo NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  3        index the search starts from (must be < NUM_REQ)
//   en    in  1        when low, no grant is produced
//   grant out NUM_REQ  one-hot winner
//   idx   out 3        encoded winner index
//   any   out 1        a winner was found
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         idx,
    output logic               any
);

    logic [3:0] cand;

    // Walk offsets 0..NUM_REQ-1 from ptr; the first valid candidate wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 4'(ptr) + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (en && !any && (4'(i) == cand) && req[i]) begin
                    grant[i] = 1'b1;
                    idx      = 3'(i);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one serial transmit line between NUM_REQ packet sources. A round-robin
// winner's packet is latched and framed as preamble 0,1,1,1,1,1 followed by
// PKT_W data bits MSB-first, then GAP_CYC idle-high cycles before the next grant.
// Ports:
//   clk         in  1              system clock, rising edge
//   rst         in  1              asynchronous active-high reset
//   req_valid   in  NUM_REQ        requester i has a packet pending
//   req_packet  in  NUM_REQ*PKT_W  packet of requester i at [i*PKT_W +: PKT_W]
//   req_ready   out NUM_REQ        one-cycle one-hot accept pulse
//   S_Data      out 1              serial line, idle high
//   busy        out 1              frame or gap in progress
//   grant_id    out 3              requester being transmitted (valid while busy)
// Optional build macro TXARB_PRIO_EN: requester 0 gets strict priority and its
// grants leave the round-robin pointer untouched.
module serial_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PKT_W   = token_link_pkg::PKT_W,
    parameter int unsigned GAP_CYC = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*PKT_W-1:0] req_packet,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     S_Data,
    output logic                     busy,
    output logic [2:0]               grant_id
);

    import token_link_pkg::*;

    if ((GAP_CYC < GAP_MIN) || (NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_param_check
        $error("serial_tx_arbiter: unsupported parameter set");
    end

    tx_state_t          state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [PKT_W-1:0]   shift, shift_next;
    logic [2:0]         ptr, ptr_next;
    logic [NUM_REQ-1:0] ready_next;
    logic               s_data_next;
    logic               busy_next;
    logic [ID_W-1:0]    grant_next;

    logic [NUM_REQ-1:0] arb_grant;
    logic [2:0]         arb_idx;
    logic               arb_any;
    logic               prio_hit;
    logic [NUM_REQ-1:0] win_oh;
    logic [2:0]         win_idx;
    logic               win_any;
    logic [PKT_W-1:0]   pkt_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (state == ST_IDLE),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Strict priority override for requester 0.
`ifdef TXARB_PRIO_EN
    assign prio_hit = (state == ST_IDLE) && req_valid[0];
`else
    assign prio_hit = 1'b0;
`endif

    assign win_oh  = prio_hit ? {{(NUM_REQ-1){1'b0}}, 1'b1} : arb_grant;
    assign win_idx = prio_hit ? 3'd0 : arb_idx;
    assign win_any = prio_hit | arb_any;

    // Winner's packet; one-hot select keeps part-select bases constant.
    always_comb begin
        pkt_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                pkt_sel = req_packet[i*PKT_W +: PKT_W];
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shift     <= '0;
            ptr       <= '0;
            req_ready <= '0;
            S_Data    <= 1'b1;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            shift     <= shift_next;
            ptr       <= ptr_next;
            req_ready <= ready_next;
            S_Data    <= s_data_next;
            busy      <= busy_next;
            grant_id  <= grant_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shift_next  = shift;
        ptr_next    = ptr;
        ready_next  = '0;
        s_data_next = 1'b1;
        busy_next   = busy;
        grant_next  = grant_id;

        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    ready_next = win_oh;
                    shift_next = pkt_sel;
                    grant_next = win_idx;
                    busy_next  = 1'b1;
                    state_next = ST_PRE;
                    cnt_next   = CNT_W'(PRE_LEN - 1);
                    if (!prio_hit) begin
                        ptr_next = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
                    end
                end
            end
            ST_PRE: begin
                s_data_next = PREAMBLE[cnt[2:0]];
                if (cnt == '0) begin
                    state_next = ST_DATA;
                    cnt_next   = CNT_W'(PKT_W - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_DATA: begin
                // Shifting left presents shift[cnt] MSB-first without a variable index.
                s_data_next = shift[PKT_W-1];
                shift_next  = {shift[PKT_W-2:0], 1'b0};
                if (cnt == '0) begin
                    state_next = ST_GAP;
                    cnt_next   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: a background monitor predicts each grant from a
// round-robin reference, queues the granted packet, and a serial receiver model
// decodes S_Data and pops/compares frames. Scenario tasks run in sequence.
module tb_serial_tx_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 55;
    localparam int unsigned GAP  = 3;
    localparam int unsigned SLOT = 6 + W + GAP + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_packet = '0;
    logic [N-1:0]   req_ready;
    logic           S_Data;
    logic           busy;
    logic [2:0]     grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];
    int           g_idx[$];
    int           g_cyc[$];
    int           mptr      = 0;
    int           n_grants  = 0;
    int           rx_frames = 0;
    int           rx_st     = 0;
    int           rx_ones   = 0;
    int           rx_bits   = 0;
    logic [W-1:0] rx_sr     = '0;
    logic [W-1:0] rx_exp;
    bit           prev_ready = 1'b0;
    int           mw, mobs;
    bit           mprio;
    logic [N-1:0] exp_oh;

    serial_tx_arbiter #(
        .NUM_REQ (N),
        .PKT_W   (W),
        .GAP_CYC (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_packet (req_packet),
        .req_ready  (req_ready),
        .S_Data     (S_Data),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int model_winner(input logic [N-1:0] v, input int p);
`ifdef TXARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Grant predictor and serial receiver model.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            rx_st      = 0;
            exp_q.delete();
            mptr       = 0;
            prev_ready = 1'b0;
        end else begin
            if (req_ready != '0) begin
                mw = model_winner(req_valid, mptr);
`ifdef TXARB_PRIO_EN
                mprio = req_valid[0];
`else
                mprio = 1'b0;
`endif
                mobs = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) mobs = i;
                exp_oh = '0;
                if (mw >= 0) exp_oh[mw] = 1'b1;
                checks++;
                if (prev_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_pulse_width: req_ready high on consecutive cycles at cycle %0d", cyc);
                end
                checks++;
                if (req_ready !== exp_oh) begin
                    errors++;
                    $display("FAIL grant_onehot: got %b expected %b (ptr %0d)", req_ready, exp_oh, mptr);
                end
                if (mw >= 0) begin
                    checks++;
                    if (grant_id !== 3'(mw)) begin
                        errors++;
                        $display("FAIL grant_id: got %0d expected %0d", grant_id, mw);
                    end
                    exp_q.push_back(req_packet[mw*W +: W]);
                    if (!mprio) mptr = (mw + 1) % N;
                end
                n_grants++;
                g_idx.push_back(mobs);
                g_cyc.push_back(cyc);
            end
            prev_ready = (req_ready != '0);

            case (rx_st)
                0: if (S_Data === 1'b0) begin
                    rx_st   = 1;
                    rx_ones = 0;
                end
                1: begin
                    checks++;
                    if (S_Data !== 1'b1) begin
                        errors++;
                        $display("FAIL rx_preamble: got %b expected 1 after %0d ones", S_Data, rx_ones);
                        rx_st = 0;
                    end else begin
                        rx_ones++;
                        if (rx_ones == 5) begin
                            rx_st   = 2;
                            rx_bits = 0;
                            rx_sr   = '0;
                        end
                    end
                end
                default: begin
                    rx_sr = {rx_sr[W-2:0], S_Data};
                    rx_bits++;
                    if (rx_bits == int'(W)) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rx_unexpected: got frame %h expected no frame", rx_sr);
                        end else begin
                            rx_exp = exp_q.pop_front();
                            if (rx_sr !== rx_exp) begin
                                errors++;
                                $display("FAIL rx_packet: got %h expected %h", rx_sr, rx_exp);
                            end
                        end
                        rx_frames++;
                        rx_st = 0;
                    end
                end
            endcase
        end
    end

    task automatic set_pkt(input int i, input logic [W-1:0] v);
        req_packet[i*W +: W] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (S_Data !== 1'b1) begin errors++; $display("FAIL reset_sdata: got %b expected 1", S_Data); end
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [W-1:0] pkt;
        logic         exp_sd;
        bit           ok;
        pkt = 55'h2A_AAAA_AAAA_AAAA;
        @(negedge clk);
        for (int i = 0; i < N; i++) set_pkt(i, W'({$urandom(), $urandom()}));
        set_pkt(2, pkt);
        req_valid = 4'b0100;
        wait_grant(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_grant_timeout: got no req_ready expected pulse"); return; end
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        checks++;
        if (busy !== 1'b1 || grant_id !== 3'd2) begin
            errors++; $display("FAIL single_busy_gid: got busy %b gid %0d expected 1 / 2", busy, grant_id);
        end
        @(negedge clk);
        req_valid = '0;
        for (int j = 1; j <= 66; j++) begin
            @(posedge clk);
            #1;
            if (j <= 6)       exp_sd = (j == 1) ? 1'b0 : 1'b1;
            else if (j <= 61) exp_sd = pkt[W - 1 - (j - 7)];
            else              exp_sd = 1'b1;
            checks++;
            if (S_Data !== exp_sd) begin errors++; $display("FAIL single_sdata: cycle +%0d got %b expected %b", j, S_Data, exp_sd); end
            checks++;
            if (busy !== (j <= 63)) begin errors++; $display("FAIL single_busy: cycle +%0d got %b expected %b", j, busy, (j <= 63)); end
            if (j == 1) begin
                checks++;
                if (req_ready !== '0) begin errors++; $display("FAIL single_ready_len: got %b expected 0", req_ready); end
            end
        end
    endtask

    task automatic test_round_robin();
        int  exp_order[5] = '{0, 1, 2, 3, 0};
        bit  ok;
        do_reset();
        g_idx.delete();
        g_cyc.delete();
        for (int i = 0; i < N; i++) set_pkt(i, W'({$urandom(), $urandom()}));
        req_valid = 4'b1111;
        for (int i = 0; i < 5 * SLOT + 20; i++) begin
            @(posedge clk);
            #2;
            if (g_idx.size() >= 5) break;
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (g_idx.size() < 5) begin
            errors++; $display("FAIL rr_timeout: got %0d grants expected 5", g_idx.size());
            return;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (g_idx[k] != exp_order[k]) begin errors++; $display("FAIL rr_order: grant %0d got %0d expected %0d", k, g_idx[k], exp_order[k]); end
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (g_cyc[k] - g_cyc[k-1] != int'(SLOT)) begin
                errors++; $display("FAIL rr_spacing: grant %0d got %0d cycles expected %0d", k, g_cyc[k] - g_cyc[k-1], SLOT);
            end
        end
        wait_idle(SLOT + 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_idle_timeout: got busy expected idle"); end
    endtask

    task automatic test_packet_change();
        int frames0;
        bit ok;
        frames0 = rx_frames;
        @(negedge clk);
        set_pkt(1, W'({$urandom(), $urandom()}));
        req_valid = 4'b0010;
        wait_grant(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL chg_grant_timeout: got no req_ready expected pulse"); return; end
        @(negedge clk);
        set_pkt(1, ~req_packet[1*W +: W]);
        req_valid = '0;
        repeat (20) @(negedge clk);
        set_pkt(1, W'({$urandom(), $urandom()}));
        wait_idle(SLOT + 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL chg_idle_timeout: got busy expected idle"); end
        checks++;
        if (rx_frames != frames0 + 1) begin errors++; $display("FAIL chg_frames: got %0d expected %0d", rx_frames - frames0, 1); end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] p0;
        bit           ok;
        do_reset();
        p0 = W'({$urandom(), $urandom()});
        p0[W-21] = 1'b0;
        set_pkt(0, p0);
        set_pkt(2, W'({$urandom(), $urandom()}));
        req_valid = 4'b0001;
        wait_grant(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmf_grant_timeout: got no req_ready expected pulse"); return; end
        @(negedge clk);
        req_valid = 4'b0101;
        @(posedge clk);
        repeat (26) @(posedge clk);
        #1;
        checks++;
        if (S_Data !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rmf_bit20: got sdata %b busy %b expected 0 / 1", S_Data, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (S_Data !== 1'b1) begin errors++; $display("FAIL rmf_sdata: got %b expected 1", S_Data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b expected 0", busy); end
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL rmf_ready: got %b expected 0", req_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_grant(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmf_regrant_timeout: got no req_ready expected pulse"); return; end
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmf_regrant: got %b expected 0001", req_ready); end
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (S_Data !== ((j == 1) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL rmf_preamble: bit %0d got %b expected %b", j, S_Data, (j == 1) ? 1'b0 : 1'b1);
            end
        end
        @(negedge clk);
        req_valid = '0;
        wait_idle(SLOT + 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmf_idle_timeout: got busy expected idle"); end
    endtask

    task automatic test_priority();
`ifdef TXARB_PRIO_EN
        int exp_order[4] = '{0, 0, 0, 0};
`else
        int exp_order[4] = '{0, 1, 0, 1};
`endif
        bit ok;
        do_reset();
        g_idx.delete();
        g_cyc.delete();
        set_pkt(0, W'({$urandom(), $urandom()}));
        set_pkt(1, W'({$urandom(), $urandom()}));
        req_valid = 4'b0011;
        for (int i = 0; i < 4 * SLOT + 20; i++) begin
            @(posedge clk);
            #2;
            if (g_idx.size() >= 4) break;
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (g_idx.size() < 4) begin
            errors++; $display("FAIL prio_timeout: got %0d grants expected 4", g_idx.size());
            return;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g_idx[k] != exp_order[k]) begin errors++; $display("FAIL prio_order: grant %0d got %0d expected %0d", k, g_idx[k], exp_order[k]); end
        end
        wait_idle(SLOT + 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL prio_idle_timeout: got busy expected idle"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_change();
        test_reset_mid_frame();
        test_priority();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d queued frames expected 0", exp_q.size()); end
        checks++;
        if (rx_frames != n_grants - 1) begin
            errors++; $display("FAIL sb_frame_count: got %0d frames expected %0d", rx_frames, n_grants - 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
